// File: rtl/wb_fabric.sv
// wb_fabric: one Wishbone master to NUM_SLAVES decoded windows plus a default
// port. The selected target is registered once per strobe burst and held while
// CYC stays high. Also provides the timeout, unmapped-address error responses
// and a sticky first-error capture register.
module wb_fabric #(
    parameter int                        NUM_SLAVES = 5,
    parameter logic [32*NUM_SLAVES-1:0]  SLV_BASE   = {NUM_SLAVES{32'hFFFFFFE0}},
    parameter logic [32*NUM_SLAVES-1:0]  SLV_MASK   = {NUM_SLAVES{32'hFFFFFFE0}},
    parameter int                        DEFAULT_EN = 1,
    parameter int                        TIMEOUT    = 255,
    parameter int                        TO_W       = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_wb_cyc,
    input  logic                         i_wb_stb,
    input  logic                         i_wb_we,
    input  logic [31:0]                  i_wb_adr,
    input  logic [31:0]                  i_wb_dat,
    input  logic [3:0]                   i_wb_sel,
    input  logic [2:0]                   i_wb_cti,
    output logic [31:0]                  o_wb_dat,
    output logic                         o_wb_ack,
    output logic                         o_wb_err,
    output logic [NUM_SLAVES:0]          o_s_cyc,
    output logic [NUM_SLAVES:0]          o_s_stb,
    input  logic [NUM_SLAVES:0]          i_s_ack,
    input  logic [NUM_SLAVES:0]          i_s_err,
    input  logic [32*(NUM_SLAVES+1)-1:0] i_s_dat,
    output logic                         o_err_valid,
    output logic [31:0]                  o_err_adr,
    output logic [1:0]                   o_err_code,
    input  logic                         i_err_clr
);
    localparam int SW = $clog2(NUM_SLAVES + 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACTIVE, ERR, WAIT} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     sel_q, sel_d, dec_sel;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0] hit;
    logic              dec_mapped;
    logic              err_set;
    logic [1:0]        err_code_d;

    // Write data, byte selects and write enable are fanned out outside the fabric;
    // CTI needs no special handling because bursts simply stay in ACTIVE.
    logic unused_inputs;
    assign unused_inputs = ^{i_wb_we, i_wb_dat, i_wb_sel, i_wb_cti};

    // Per-window address match.
    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_dec
        assign hit[g] = ((i_wb_adr ^ SLV_BASE[32*g +: 32]) & SLV_MASK[32*g +: 32]) == 32'd0;
    end

    // Priority pick: the lowest matching window wins; no match selects the default port.
    always_comb begin
        dec_sel = SW'(NUM_SLAVES);
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) dec_sel = SW'(i);
        end
    end

    assign dec_mapped = (|hit) || (DEFAULT_EN != 0);

    // Next-state logic, slave strobe routing and master response muxing.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        o_s_cyc    = '0;
        o_s_stb    = '0;
        o_wb_ack   = 1'b0;
        o_wb_err   = 1'b0;
        o_wb_dat   = 32'd0;
        err_set    = 1'b0;
        err_code_d = 2'b00;
        case (state_q)
            IDLE, WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = IDLE;
                end else if (i_wb_stb) begin
                    if (dec_mapped) begin
                        state_d = ACTIVE;
                        sel_d   = dec_sel;
                        cnt_d   = '0;
                    end else begin
                        state_d    = ERR;
                        err_set    = 1'b1;
                        err_code_d = 2'b01;
                    end
                end
            end
            ACTIVE: begin
                if (!i_wb_cyc) begin
                    state_d = IDLE;
                end else if (i_wb_stb && (!dec_mapped || dec_sel != sel_q)) begin
                    // Target changed under a held CYC: abort without strobing anyone.
                    state_d    = ERR;
                    err_set    = 1'b1;
                    err_code_d = 2'b01;
                end else if (TIMEOUT != 0 && cnt_q == TO_LIM) begin
                    state_d    = ERR;
                    err_set    = 1'b1;
                    err_code_d = 2'b10;
                end else begin
                    o_s_cyc[sel_q] = 1'b1;
                    o_s_stb[sel_q] = i_wb_stb;
                    o_wb_err       = i_s_err[sel_q];
                    o_wb_ack       = i_s_ack[sel_q] & ~i_s_err[sel_q];
                    o_wb_dat       = i_s_dat[32*int'(sel_q) +: 32];
                    if (i_s_ack[sel_q] || i_s_err[sel_q]) cnt_d = '0;
                    else if (i_wb_stb)                    cnt_d = cnt_q + TO_W'(1);
                    if (i_s_err[sel_q]) begin
                        err_set    = 1'b1;
                        err_code_d = 2'b11;
                    end
                end
            end
            ERR: begin
                o_wb_err = 1'b1;
                if (!i_wb_cyc) begin
                    state_d = IDLE;
                end else if (i_wb_stb && dec_mapped) begin
                    state_d = ACTIVE;
                    sel_d   = dec_sel;
                    cnt_d   = '0;
                end else begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, latched selection and stall counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sticky first-error capture; a clear beats a simultaneous new error.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_err_valid <= 1'b0;
            o_err_adr   <= 32'd0;
            o_err_code  <= 2'b00;
        end else if (i_err_clr) begin
            o_err_valid <= 1'b0;
            o_err_adr   <= 32'd0;
            o_err_code  <= 2'b00;
        end else if (err_set && !o_err_valid) begin
            o_err_valid <= 1'b1;
            o_err_adr   <= i_wb_adr;
            o_err_code  <= err_code_d;
        end
    end
endmodule

// File: tb/tb_wb_fabric.sv
// tb_wb_fabric: directed checks of wb_fabric with five windows, no default
// routing and an 8-cycle timeout. Slave responders are registered models with
// a per-slave ack latency (0 = never acks).
module tb_wb_fabric;
    localparam int NS = 5;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [31:0] i_wb_adr, i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic [2:0]  i_wb_cti;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack, o_wb_err;
    logic [NS:0] o_s_cyc, o_s_stb, i_s_ack, i_s_err;
    logic [32*(NS+1)-1:0] i_s_dat;
    logic        o_err_valid;
    logic [31:0] o_err_adr;
    logic [1:0]  o_err_code;
    logic        i_err_clr;

    logic [NS:0] s_ack_r, ack_force, err_force;
    int          lat   [NS+1];
    int          wcnt  [NS+1];
    int          beats [NS+1];
    int          nchk = 0;
    int          nerr = 0;

    wb_fabric #(
        .NUM_SLAVES (NS),
        .SLV_BASE   ({32'h40000000, 32'h20000000, 32'h20000000, 32'hFFFFFFC0, 32'hFFFFFFE0}),
        .SLV_MASK   ({32'hFFFF0000, 32'hFFFFF000, 32'hFFFF0000, 32'hFFFFFFE0, 32'hFFFFFFE0}),
        .DEFAULT_EN (0),
        .TIMEOUT    (8),
        .TO_W       (8)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel), .i_wb_cti(i_wb_cti),
        .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
        .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .i_s_ack(i_s_ack), .i_s_err(i_s_err),
        .i_s_dat(i_s_dat),
        .o_err_valid(o_err_valid), .o_err_adr(o_err_adr), .o_err_code(o_err_code),
        .i_err_clr(i_err_clr)
    );

    initial forever #5 i_clk = ~i_clk;

    assign i_s_ack = s_ack_r | ack_force;
    assign i_s_err = err_force;

    // Slave read data: 0xA5A5_0001 + 0x100*slave + beats already acked.
    always_comb begin
        for (int k = 0; k <= NS; k++)
            i_s_dat[32*k +: 32] = 32'hA5A50001 + 32'(k) * 32'd256 + 32'(beats[k]);
    end

    // Registered slave responders: ack lat[k] cycles after the strobe is seen.
    always @(posedge i_clk) begin
        for (int k = 0; k <= NS; k++) begin
            if (o_s_stb[k] && !s_ack_r[k] && lat[k] > 0) begin
                if (wcnt[k] == lat[k] - 1) s_ack_r[k] <= 1'b1;
                else                       wcnt[k]    <= wcnt[k] + 1;
            end else begin
                if (s_ack_r[k]) beats[k] <= beats[k] + 1;
                s_ack_r[k] <= 1'b0;
                wcnt[k]    <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic nedge(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic start(input logic [31:0] adr, input logic [2:0] cti);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_adr = adr; i_wb_cti = cti;
    endtask

    task automatic stop();
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_cti = 3'b000;
    endtask

    task automatic clr_err();
        nedge(1); i_err_clr = 1'b1;
        nedge(1); i_err_clr = 1'b0;
    endtask

    initial begin
        int n, beat;
        i_reset = 1'b1; stop(); i_wb_we = 1'b0; i_wb_adr = '0; i_wb_dat = 32'h12345678;
        i_wb_sel = 4'hF; i_err_clr = 1'b0; ack_force = '0; err_force = '0; s_ack_r = '0;
        for (int k = 0; k <= NS; k++) begin lat[k] = 0; wcnt[k] = 0; beats[k] = 0; end
        lat[0] = 2; lat[2] = 1;
        #1;
        chk("rst_s_cyc", 32'(o_s_cyc), 32'd0);
        chk("rst_s_stb", 32'(o_s_stb), 32'd0);
        chk("rst_ack_err_dat", {o_wb_dat[29:0], o_wb_ack, o_wb_err}, 32'd0);
        chk("rst_err_regs", {29'd0, o_err_valid, o_err_code}, 32'd0);
        chk("rst_err_adr", o_err_adr, 32'd0);
        nedge(1); i_reset = 1'b0;

        // 1: single read, slave0 acks 2 cycles after its strobe
        start(32'hFFFFFFE4, 3'b000); #1;
        chk("t1_idle_stb", 32'(o_s_stb), 32'd0);
        nedge(1);
        chk("t1_stb_rise", 32'(o_s_stb), 32'h01);
        chk("t1_no_ack_early", 32'(o_wb_ack), 32'd0);
        nedge(1);
        chk("t1_stb_hold", 32'(o_s_stb), 32'h01);
        chk("t1_no_ack_mid", 32'(o_wb_ack), 32'd0);
        nedge(1);
        chk("t1_ack", 32'(o_wb_ack), 32'd1);
        chk("t1_dat", o_wb_dat, 32'hA5A50001);
        chk("t1_stb_at_ack", 32'(o_s_stb), 32'h01);
        stop();
        nedge(1);
        chk("t1_idle_after", 32'({o_s_cyc, o_s_stb}), 32'd0);

        // 2: unmapped read gets a one-cycle error and is captured
        start(32'h10000000, 3'b000);
        nedge(1);
        chk("t2_err", {o_wb_err, o_wb_ack}, 32'd2);
        chk("t2_dat", o_wb_dat, 32'd0);
        chk("t2_err_valid", 32'(o_err_valid), 32'd1);
        chk("t2_err_adr", o_err_adr, 32'h10000000);
        chk("t2_err_code", 32'(o_err_code), 32'd1);
        chk("t2_no_strobe", 32'(o_s_stb), 32'd0);
        i_wb_stb = 1'b0;
        nedge(1);
        chk("t2_err_once", 32'(o_wb_err), 32'd0);
        stop();
        clr_err();
        chk("t2_cleared", 32'(o_err_valid), 32'd0);

        // 3: slave1 never acks, timeout after 8 stalled cycles
        start(32'hFFFFFFC4, 3'b000);
        nedge(1);
        n = 0;
        while (o_s_stb[1] && n < 20) begin
            n++;
            nedge(1);
        end
        chk("t3_stall_cycles", 32'(n), 32'd8);
        chk("t3_drop_no_err", 32'(o_wb_err), 32'd0);
        nedge(1);
        chk("t3_err", 32'(o_wb_err), 32'd1);
        chk("t3_err_code", 32'(o_err_code), 32'd2);
        chk("t3_err_adr", o_err_adr, 32'hFFFFFFC4);
        stop();
        nedge(1);
        chk("t3_err_once", 32'(o_wb_err), 32'd0);
        clr_err();

        // 4: 4-beat incrementing burst; 0x2000_0000 hits windows 2 and 3, 2 wins
        start(32'h20000000, 3'b010);
        beat = 0; n = 0;
        while (beat < 4 && n < 30) begin
            n++;
            nedge(1);
            chk("t4_sel_held", 32'(o_s_cyc), 32'h04);
            if (o_wb_ack) begin
                chk("t4_beat_dat", o_wb_dat, 32'hA5A50201 + 32'(beat));
                beat++;
                if (beat == 4) stop();
                else begin
                    i_wb_adr = i_wb_adr + 32'd4;
                    i_wb_cti = (beat == 3) ? 3'b111 : 3'b010;
                end
            end
        end
        chk("t4_beats", 32'(beat), 32'd4);
        nedge(1);
        chk("t4_idle", 32'({o_s_cyc, o_s_stb}), 32'd0);
        chk("t4_no_err", 32'({o_wb_err, o_err_valid}), 32'd0);

        // 5: target change under held cyc, then sticky and clear-priority checks
        start(32'hFFFFFFE0, 3'b000);
        nedge(1);
        chk("t5_sel0", 32'(o_s_stb), 32'h01);
        i_wb_adr = 32'h40000000; #1;
        chk("t5_change_no_stb", 32'(o_s_stb), 32'd0);
        nedge(1);
        chk("t5_change_err", 32'(o_wb_err), 32'd1);
        chk("t5_change_adr", o_err_adr, 32'h40000000);
        chk("t5_change_code", 32'(o_err_code), 32'd1);
        stop();
        nedge(1);
        start(32'h10000000, 3'b000);
        nedge(1);
        chk("t5_second_err", 32'(o_wb_err), 32'd1);
        chk("t5_sticky_adr", o_err_adr, 32'h40000000);
        stop();
        nedge(1);
        start(32'h50000000, 3'b000); i_err_clr = 1'b1;
        nedge(1);
        i_err_clr = 1'b0;
        chk("t5_clr_valid", 32'(o_err_valid), 32'd0);
        chk("t5_clr_adr", o_err_adr, 32'd0);
        chk("t5_clr_code", 32'(o_err_code), 32'd0);
        stop();
        nedge(1);
        start(32'h10000000, 3'b000); i_err_clr = 1'b1;
        nedge(1);
        i_err_clr = 1'b0;
        chk("t5_clr_beats_new", 32'({o_err_valid, o_err_code}), 32'd0);
        stop();
        nedge(1);

        // 6: reset asserted mid-transaction
        start(32'hFFFFFFC4, 3'b000);
        nedge(1);
        chk("t6_active", 32'(o_s_stb), 32'h02);
        #2 i_reset = 1'b1;
        #1;
        chk("t6_rst_async", 32'({o_s_cyc, o_s_stb}), 32'd0);
        stop();
        nedge(1);
        i_reset = 1'b0;
        start(32'hFFFFFFE0, 3'b000); #1;
        chk("t6_idle_after_rst", 32'(o_s_stb), 32'd0);
        nedge(1);
        chk("t6_restart", 32'(o_s_stb), 32'h01);
        stop();
        nedge(2);

        // 7: slave raises ack and err together: err wins and is captured as 11
        start(32'h40000000, 3'b000);
        nedge(1);
        ack_force = 6'h10; err_force = 6'h10; #1;
        chk("t7_err_wins", {o_wb_err, o_wb_ack}, 32'd2);
        nedge(1);
        chk("t7_code", 32'(o_err_code), 32'd3);
        chk("t7_adr", o_err_adr, 32'h40000000);
        ack_force = '0; err_force = '0;
        stop();
        nedge(2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
